column_renderer: RTL and testbench

COLUMN_RENDERER -- requirements
Module: column_renderer

---
 rtl/ray_pkg.sv | 17 +
 rtl/vga_timing.sv | 67 ++++++
 rtl/column_renderer.sv | 203 ++++++++++++++++++++
 tb/tb_column_renderer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared column-entry type and RGB332 shading helper for the column renderer.
package ray_pkg;

  localparam int CNT_W = 11;

  typedef struct packed {
    logic [9:0] height;
    logic [7:0] color;
    logic       y_side;
  } column_t;

  // Halve each RGB332 channel so y-facing walls read darker.
  function automatic logic [7:0] shade332(input logic [7:0] c);
    return {1'b0, c[7:6], 1'b0, c[4:3], 1'b0, c[1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with active-video, sync and buffer-swap-point decode.
module vga_timing
  import ray_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 600,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_FRONT       = 1,
  parameter int V_SYNC        = 4,
  parameter int V_BACK        = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             swap_pt_o
);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(SCREEN_WIDTH);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(SCREEN_WIDTH + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(SCREEN_HEIGHT + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Next raster position: v advances only when h wraps.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = {CNT_W{1'b0}};
      if (v_cnt_q == V_LAST) v_cnt_d = {CNT_W{1'b0}};
      else                   v_cnt_d = v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  // Raster position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= {CNT_W{1'b0}};
      v_cnt_q <= {CNT_W{1'b0}};
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o   = h_cnt_q;
  assign v_cnt_o   = v_cnt_q;
  assign active_o  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o   = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vsync_o   = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign swap_pt_o = (v_cnt_q == V_ACT) && (h_cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/column_renderer.sv
// Double-buffered column RAM rendered as ceiling / wall / floor onto a VGA raster.
// Define RENDERER_SHADE_EN to store y_side and darken y-facing wall pixels.
module column_renderer
  import ray_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 600,
  parameter int         H_FRONT       = 16,
  parameter int         H_SYNC        = 96,
  parameter int         H_BACK        = 48,
  parameter int         V_FRONT       = 1,
  parameter int         V_SYNC        = 4,
  parameter int         V_BACK        = 23,
  parameter logic [7:0] CEIL_COLOR    = 8'h49,
  parameter logic [7:0] FLOOR_COLOR   = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       col_valid,
  input  logic [9:0] col_index,
  input  logic [9:0] col_height,
  input  logic [7:0] col_color,
  input  logic       col_y_side,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_valid,
  output logic [7:0] pixel_color,
  output logic       frame_swap
);

`ifdef RENDERER_SHADE_EN
  localparam int MEM_W = 19;
`else
  localparam int MEM_W = 18;
`endif
  localparam int          AW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam logic [10:0] SH = 11'(SCREEN_HEIGHT);

  logic [CNT_W-1:0] h_cnt_s, v_cnt_s;
  logic             active_s, hs_s, vs_s, swap_pt_s;

  vga_timing #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .H_FRONT      (H_FRONT),
    .H_SYNC       (H_SYNC),
    .H_BACK       (H_BACK),
    .V_FRONT      (V_FRONT),
    .V_SYNC       (V_SYNC),
    .V_BACK       (V_BACK)
  ) u_timing (
    .clk_i    (clk),
    .rst_i    (rst),
    .h_cnt_o  (h_cnt_s),
    .v_cnt_o  (v_cnt_s),
    .active_o (active_s),
    .hsync_o  (hs_s),
    .vsync_o  (vs_s),
    .swap_pt_o(swap_pt_s)
  );

  logic [MEM_W-1:0] buf_q [2][SCREEN_WIDTH];
  logic [MEM_W-1:0] rd_word_q;
  logic [MEM_W-1:0] wr_word_s;
  logic [AW-1:0]    wr_addr_s, rd_addr_s;
  logic             wr_en_s, wr_sel_s, swap_s;
  logic             front_sel_q, front_sel_d;
  logic             frame_complete_q, frame_complete_d;
  logic             shown_q, shown_d;
  logic             act_p_q, hs_p_q, vs_p_q;
  logic [CNT_W-1:0] v_p_q;
  column_t          col_s;
  logic [10:0]      ht_s, top_s;
  logic             wall_s, ceil_s;
  logic [7:0]       pixel_color_d;
  logic             hsync_q, vsync_q, pixel_valid_q, frame_swap_q;
  logic [7:0]       pixel_color_q;

  assign wr_en_s   = col_valid && !rst && ({1'b0, col_index} < 11'(SCREEN_WIDTH));
  assign wr_addr_s = AW'(col_index);
  assign rd_addr_s = AW'(h_cnt_s);
  assign wr_sel_s  = ~front_sel_d;
`ifdef RENDERER_SHADE_EN
  assign wr_word_s = {col_height, col_color, col_y_side};
`else
  assign wr_word_s = {col_height, col_color};
  logic unused_y_side_s;
  assign unused_y_side_s = col_y_side;
`endif

  // Swap decision: a write in the swap cycle lands in the post-swap back buffer.
  always_comb begin
    swap_s      = swap_pt_s && frame_complete_q;
    front_sel_d = front_sel_q ^ swap_s;
    shown_d     = shown_q | swap_s;
    frame_complete_d = frame_complete_q;
    if (swap_pt_s) begin
      frame_complete_d = 1'b0;
    end else if (wr_en_s && (col_index == 10'(SCREEN_WIDTH - 1))) begin
      frame_complete_d = 1'b1;
    end else begin
      frame_complete_d = frame_complete_q;
    end
  end

  // Buffer bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel_q      <= 1'b0;
      frame_complete_q <= 1'b0;
      shown_q          <= 1'b0;
    end else begin
      front_sel_q      <= front_sel_d;
      frame_complete_q <= frame_complete_d;
      shown_q          <= shown_d;
    end
  end

  // Column RAM write port (contents deliberately survive reset).
  always_ff @(posedge clk) begin
    if (wr_en_s) buf_q[wr_sel_s][wr_addr_s] <= wr_word_s;
  end

  // Column RAM read port, one clock of latency.
  always_ff @(posedge clk) begin
    if (active_s) rd_word_q <= buf_q[front_sel_q][rd_addr_s];
  end

  // Stage one: raster controls aligned with the RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_p_q <= 1'b0;
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      v_p_q   <= {CNT_W{1'b0}};
    end else begin
      act_p_q <= active_s;
      hs_p_q  <= hs_s;
      vs_p_q  <= vs_s;
      v_p_q   <= v_cnt_s;
    end
  end

  // Unpack the RAM word; y_side reads as zero when it is not stored.
  always_comb begin
    col_s.height = rd_word_q[MEM_W-1 -: 10];
    col_s.color  = rd_word_q[MEM_W-11 -: 8];
`ifdef RENDERER_SHADE_EN
    col_s.y_side = rd_word_q[0];
`else
    col_s.y_side = 1'b0;
`endif
  end

  // Row classification; before the first swap every column behaves as height zero.
  always_comb begin
    ht_s   = shown_q ? {1'b0, col_s.height} : 11'd0;
    top_s  = 11'd0;
    wall_s = 1'b0;
    ceil_s = 1'b0;
    if (ht_s >= SH) begin
      wall_s = 1'b1;
      ceil_s = 1'b0;
    end else begin
      top_s  = (SH - ht_s) >> 1;
      wall_s = (v_p_q >= top_s) && (v_p_q < (top_s + ht_s));
      ceil_s = (v_p_q < top_s);
    end
  end

  // Pixel colour selection.
  always_comb begin
    pixel_color_d = 8'h00;
    if (!act_p_q)    pixel_color_d = 8'h00;
    else if (wall_s) pixel_color_d = col_s.y_side ? shade332(col_s.color) : col_s.color;
    else if (ceil_s) pixel_color_d = CEIL_COLOR;
    else             pixel_color_d = FLOOR_COLOR;
  end

  // Output stage: every display-facing signal leaves from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      pixel_valid_q <= 1'b0;
      pixel_color_q <= 8'h00;
      frame_swap_q  <= 1'b0;
    end else begin
      hsync_q       <= hs_p_q;
      vsync_q       <= vs_p_q;
      pixel_valid_q <= act_p_q;
      pixel_color_q <= pixel_color_d;
      frame_swap_q  <= swap_s;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_color = pixel_color_q;
  assign frame_swap  = frame_swap_q;

endmodule

// File: tb/tb_column_renderer.sv
// Scoreboard bench for column_renderer on a reduced raster; honours RENDERER_SHADE_EN.
`timescale 1ns/1ps
module tb_column_renderer;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam logic [7:0] CEIL  = 8'h49;
  localparam logic [7:0] FLOOR = 8'h24;
`ifdef RENDERER_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       col_valid = 1'b0;
  logic [9:0] col_index = 10'd0;
  logic [9:0] col_height = 10'd0;
  logic [7:0] col_color = 8'h00;
  logic       col_y_side = 1'b0;
  logic       hsync, vsync, pixel_valid, frame_swap;
  logic [7:0] pixel_color;

  column_renderer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CEIL_COLOR(CEIL), .FLOOR_COLOR(FLOOR)
  ) dut (
    .clk(clk), .rst(rst),
    .col_valid(col_valid), .col_index(col_index), .col_height(col_height),
    .col_color(col_color), .col_y_side(col_y_side),
    .hsync(hsync), .vsync(vsync), .pixel_valid(pixel_valid),
    .pixel_color(pixel_color), .frame_swap(frame_swap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       pv;
    logic [7:0] pc;
  } vid_t;

  typedef struct packed {
    logic       v;
    logic [9:0] idx;
    logic [9:0] ht;
    logic [7:0] c;
    logic       y;
  } pkt_t;

  localparam vid_t IDLE = '{hs: 1'b1, vs: 1'b1, pv: 1'b0, pc: 8'h00};

  vid_t vid_q[$];
  bit   swap_q[$];
  pkt_t pkt_q[$];

  // Model: two physical buffers, which one is front, and the frame flags.
  int         m_ht [2][W];
  logic [7:0] m_c  [2][W];
  bit         m_y  [2][W];
  int         m_sel;
  bit         m_complete, m_shown;

  int   t;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  vid_t mon_e;
  bit   mon_s;

  function automatic logic [7:0] wall_col(logic [7:0] c, bit y);
    int r, g, b;
    if (SHADE && y) begin
      r = (int'(c) >> 5) / 2;
      g = ((int'(c) >> 2) % 8) / 2;
      b = (int'(c) % 4) / 2;
      return 8'(r * 32 + g * 4 + b);
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_color(int hc, int vc);
    int ht, top;
    ht = m_shown ? m_ht[m_sel][hc] : 0;
    if (ht >= H) return wall_col(m_c[m_sel][hc], m_y[m_sel][hc]);
    top = (H - ht) / 2;
    if (vc < top) return CEIL;
    if (vc < top + ht) return wall_col(m_c[m_sel][hc], m_y[m_sel][hc]);
    return FLOOR;
  endfunction

  task automatic model_reset();
    m_sel = 0;
    m_complete = 1'b0;
    m_shown = 1'b0;
    t = 0;
    vid_q.delete();
    swap_q.delete();
    pkt_q.delete();
    vid_q.push_back(IDLE);
    vid_q.push_back(IDLE);
    swap_q.push_back(1'b0);
  endtask

  // One raster cycle: predict the output for this position, decide the swap, issue a packet.
  task automatic cycle_body();
    int   hc, vc;
    bit   act, swp, sw;
    vid_t e;
    pkt_t p;
    hc  = t % HT;
    vc  = (t / HT) % VT;
    act = (hc < W) && (vc < H);
    swp = (vc == H) && (hc == 0);
    e.hs = !((hc >= W + HF) && (hc < W + HF + HS));
    e.vs = !((vc >= H + VF) && (vc < H + VF + VS));
    e.pv = act;
    e.pc = act ? exp_color(hc, vc) : 8'h00;
    vid_q.push_back(e);
    sw = 1'b0;
    if (swp) begin
      sw = m_complete;
      if (sw) begin
        m_sel   = 1 - m_sel;
        m_shown = 1'b1;
      end
      m_complete = 1'b0;
    end
    swap_q.push_back(sw);
    p = '0;
    if (pkt_q.size() > 0) p = pkt_q.pop_front();
    col_valid  = p.v;
    col_index  = p.idx;
    col_height = p.ht;
    col_color  = p.c;
    col_y_side = p.y;
    if (p.v && (int'(p.idx) < W)) begin
      m_ht[1 - m_sel][p.idx] = int'(p.ht);
      m_c[1 - m_sel][p.idx]  = p.c;
      m_y[1 - m_sel][p.idx]  = p.y;
      if ((int'(p.idx) == W - 1) && !swp) m_complete = 1'b1;
    end
  endtask

  task automatic step();
    cycle_body();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until(int hx, int vx);
    for (int i = 0; i < HT * VT + 1; i++) begin
      if (((t % HT) == hx) && (((t / HT) % VT) == vx)) return;
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL step_until: position h=%0d v=%0d not reached within one frame", hx, vx);
  endtask

  task automatic push_pkt(int idx, int ht, logic [7:0] c, bit y);
    pkt_t p;
    p.v = 1'b1; p.idx = 10'(idx); p.ht = 10'(ht); p.c = c; p.y = y;
    pkt_q.push_back(p);
  endtask

  task automatic push_idle();
    pkt_q.push_back('0);
  endtask

  task automatic mid_reset();
    rst        = 1'b1;
    col_valid  = 1'b1;
    col_index  = 10'd3;
    col_height = 10'd5;
    col_color  = 8'hAA;
    col_y_side = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    col_valid = 1'b0;
    model_reset();
  endtask

  // Monitor: every cycle compare the presented outputs with the oldest predictions.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((vid_q.size() == 0) || (swap_q.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow at t=%0d: no prediction queued", t);
      end else begin
        mon_e = vid_q.pop_front();
        mon_s = swap_q.pop_front();
        n_checks++;
        if ({hsync, vsync, pixel_valid, pixel_color} !== {mon_e.hs, mon_e.vs, mon_e.pv, mon_e.pc}) begin
          n_fail++;
          $display("FAIL video t=%0d: got hs=%b vs=%b pv=%b pc=%h, expected hs=%b vs=%b pv=%b pc=%h",
                   t, hsync, vsync, pixel_valid, pixel_color, mon_e.hs, mon_e.vs, mon_e.pv, mon_e.pc);
        end
        n_checks++;
        if (frame_swap !== mon_s) begin
          n_fail++;
          $display("FAIL frame_swap t=%0d: got %b, expected %b", t, frame_swap, mon_s);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Empty frame: no swap, plain ceiling over floor.
    run(HT * VT + 5);

    // Uniform mid-height red wall, shown after the next swap.
    for (int i = 0; i < W; i++) push_pkt(i, 4, 8'hE0, 1'b0);
    run(2 * HT * VT);

    // Full-height and zero-height columns among random ones.
    for (int i = 0; i < W; i++) begin
      if (i == 5)      push_pkt(i, 700, 8'($urandom), 1'($urandom));
      else if (i == 6) push_pkt(i, 0, 8'($urandom), 1'($urandom));
      else             push_pkt(i, $urandom_range(1, H - 1), 8'($urandom), 1'($urandom));
    end
    run(2 * HT * VT);

    // White y-side wall: darkened only with shading compiled in.
    for (int i = 0; i < W; i++) push_pkt(i, 6, 8'hFF, 1'b1);
    run(2 * HT * VT);

    // Random traffic with gaps, dropped indices and occasionally incomplete frames.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < W; k++) begin
        if ($urandom_range(0, 4) == 0) push_pkt($urandom_range(W, 1023), $urandom_range(0, 1023), 8'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) push_idle();
        if ((k < W - 1) || ($urandom_range(0, 3) != 0))
          push_pkt(k, $urandom_range(0, H + 3), 8'($urandom), 1'($urandom));
      end
      run(HT * VT);
    end

    // Incomplete frame; out-of-range and last-column writes around the swap point.
    step_until(0, H);
    step();
    for (int i = 0; i < W - 1; i++) begin
      if (i == 12) push_pkt(i, 2, 8'h03, 1'b0);
      else         push_pkt(i, $urandom_range(0, H), 8'($urandom), 1'($urandom));
    end
    run(W);
    step_until(HT - 1, H - 1);
    push_pkt(700, 11, 8'h1C, 1'b0);
    step();
    push_pkt(W - 1, 9, 8'h92, 1'b0);
    step();
    run(HT * VT + 4);
    push_pkt(W - 1, 3, 8'h5A, 1'b0);
    run(2 * HT * VT);

    // Reset mid-line with a packet offered during reset, then rebuild around column 3.
    step_until(7, 3);
    mid_reset();
    run(HT * VT);
    for (int i = 0; i < W; i++) begin
      if (i != 3) push_pkt(i, $urandom_range(0, H + 1), 8'($urandom), 1'($urandom));
    end
    run(2 * HT * VT);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
